siteswap_decoder: RTL and testbench
===================================

Name: siteswap_decoder

Overview:
- Inverse of the trajectory generator: observes per-ball screen positions once per frame and recovers the siteswap throw digits being juggled.
- Sits after ball tracking (or in loopback directly on the trajectory generator outputs) and feeds the pattern-compare and score logic.
- Per-ball airborne tracking with beat-quantised flight time; decoded digits are serialised into a small FIFO with a valid/ready output.

Parameters:
- THRESH, 20, pixels above catch_y_in a ball must rise to count as airborne.
- FIFO_DEPTH, 8, output digit FIFO entries (power of 2).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- nf_in  in  1  new-frame strobe, one cycle wide
- ball_x_in[6:0]  in  11 each  ball x positions (pass-through only, not decoded)
- ball_y_in[6:0]  in  10 each  ball y positions; smaller value is higher on screen
- ball_valid  in  1  positions valid for this frame
- catch_y_in  in  10  hand/catch line y
- num_balls  in  3  active balls (0..7); ball index >= num_balls is ignored
- frame_per_beat  in  15  frames per beat
- digit_out  out  3  decoded throw digit, 1..7
- digit_ball_out  out  3  ball index that produced the digit
- digit_valid  out  1  FIFO head valid
- digit_ready  in  1  consumer accept; a pop occurs when digit_valid && digit_ready
- overflow  out  1  sticky: a digit was dropped because the FIFO was full
- frame_drop  out  1  sticky: nf_in arrived while SCAN was still in progress

Behaviour:
- Reset values: all outputs 0; FIFO empty; every ball in IN_HAND with counters at 0; FSM in IDLE.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN on nf_in && ball_valid.
  - On that transition, latch ball_y_in, catch_y_in, num_balls, and frame_per_beat. A frame_per_beat value of 0 is latched as 1.
  - nf_in with ball_valid=0: the frame is skipped; no counters advance.
- SCAN: processes one ball per cycle, index i = 0..6; ball i is handled in cycle nf+1+i. Returns to IDLE after i=6. Balls with i >= num_balls are left unchanged.
  - nf_in during SCAN: that frame is ignored and frame_drop is set.
- Per-ball state: IN_HAND/AIRBORNE, sub counter (15 bit), beats counter (3 bit, saturates at 7).
  - Airborne test: y < catch_y - THRESH, computed signed at 11 bits; a negative threshold means never airborne.
  - IN_HAND and test true: go AIRBORNE; sub=0, beats=0.
  - AIRBORNE, every processed frame, including the catch frame: if sub+1 == fpb then sub=0 and beats=sat(beats+1), else sub=sub+1.
  - AIRBORNE and test false (catch), applied after the increment:
    - digit = sat7(beats + (sub >= fpb>>1 ? 1 : 0));
    - if digit != 0, push {ball, digit};
    - go IN_HAND.
- FIFO behaviour:
  - A push in ball i's scan cycle makes the digit visible on the outputs the next cycle if the FIFO was empty.
  - Push and pop in the same cycle are both honoured when full.
  - Push when full without a pop: the entry is dropped and overflow is set.
  - Digits are emitted in ascending ball order within a frame and in frame order across frames.
- Changes to num_balls or frame_per_beat take effect at the next latched frame. Airborne balls keep their counters; a ball whose index falls at or above num_balls is frozen.
- rst_in mid-SCAN: the scan is aborted, everything returns to reset values, and sticky flags clear. Only rst_in clears the sticky flags.

Optional Feature:
- Macro SITESWAP_HOLD_DETECT_EN.
- Defined:
  - IN_HAND balls also run the sub/beats counters; the counters reset to 0 on catch and on the airborne transition.
  - When an IN_HAND ball reaches beats == 2 (sub == 0 on that frame), push digit 2 for it and restart its counters.
  - Result: held "2" throws, which the generator emits with zero vertical velocity, are reported.
- Not defined: IN_HAND balls keep no counters, and digit 2 is reported only from true airborne flights.

Test Plan:
- fpb=30, catch_y=400, num_balls=1. Ball 0 y=300 at frame 1, back to y=400 at frame 91 -> one digit {ball0, 3}, digit_valid asserted 2 cycles after the frame-91 nf_in.
- Same setup, catch at frame 105 (total 104: 3 beats rem 14) -> 3; catch at frame 106 (total 105: rem 15) -> 4.
- Airtime 300 frames -> digit 7 (saturated). Ball rises only to y=385 (not above 380) -> no digit.
- num_balls=3, balls 0/1/2 all caught in the same frame with digits 5/3/1 -> FIFO order 5,3,1 with ball ids 0,1,2. A ball-3 flight with num_balls=3 -> no output.
- digit_ready=0, 9 catches -> 8 entries held and overflow=1. Then raise digit_ready -> 8 pops in order, overflow stays 1. nf_in pulsed 3 cycles after a previous nf_in -> frame_drop=1.
- rst_in asserted during SCAN cycle 3 with an airborne ball -> all outputs 0 and FIFO empty. A following catch frame yields no digit, because the ball starts IN_HAND. With SITESWAP_HOLD_DETECT_EN and fpb=30, a ball held 60 frames -> digit 2.

Source files
------------

// File: rtl/siteswap_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : siteswap_decoder_if                                        |
// | Description : Frame/ball-position input bundle and decoded-digit output  |
// |               stream of the siteswap decoder.                            |
// |               master : ball tracker / digit consumer side                |
// |               slave  : siteswap_decoder side                             |
// | Signals     : nf_in, ball_x_in[6:0], ball_y_in[6:0], ball_valid,         |
// |               catch_y_in, num_balls, frame_per_beat, digit_ready (in);   |
// |               digit_out, digit_ball_out, digit_valid, overflow,          |
// |               frame_drop (out)                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface siteswap_decoder_if;
    logic             nf_in;
    logic [6:0][10:0] ball_x_in;
    logic [6:0][9:0]  ball_y_in;
    logic             ball_valid;
    logic [9:0]       catch_y_in;
    logic [2:0]       num_balls;
    logic [14:0]      frame_per_beat;
    logic [2:0]       digit_out;
    logic [2:0]       digit_ball_out;
    logic             digit_valid;
    logic             digit_ready;
    logic             overflow;
    logic             frame_drop;

    modport master (
        output nf_in, ball_x_in, ball_y_in, ball_valid, catch_y_in,
               num_balls, frame_per_beat, digit_ready,
        input  digit_out, digit_ball_out, digit_valid, overflow, frame_drop
    );

    modport slave (
        input  nf_in, ball_x_in, ball_y_in, ball_valid, catch_y_in,
               num_balls, frame_per_beat, digit_ready,
        output digit_out, digit_ball_out, digit_valid, overflow, frame_drop
    );
endinterface
`default_nettype wire

// File: rtl/siteswap_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : siteswap_decoder                                           |
// | Description : Recovers siteswap throw digits from per-frame ball screen  |
// |               positions. Each ball is tracked IN_HAND/AIRBORNE with a    |
// |               beat-quantised flight timer; on a catch the rounded beat   |
// |               count is pushed into a small digit FIFO.                   |
// | Ports       : clk_in  - system clock                                     |
// |               rst_in  - synchronous active-high reset                    |
// |               bus     - siteswap_decoder_if.slave (frame inputs, digit   |
// |                         stream, sticky overflow / frame_drop flags)      |
// | Options     : SITESWAP_HOLD_DETECT_EN - when defined, balls held in hand |
// |               for two beats report a digit 2.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module siteswap_decoder #(
    parameter int THRESH     = 20,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    siteswap_decoder_if.slave   bus
);

    localparam int          c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [10:0] c_THRESH    = 11'(THRESH);
    localparam logic [2:0]  c_LAST_BALL = 3'd6;

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic        w_latch;
    logic        w_scan;
    logic        w_drop;

    logic [2:0]  r_idx;
    logic [9:0]  r_y [0:6];
    logic [9:0]  r_catch;
    logic [2:0]  r_nb;
    logic [14:0] r_fpb;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_latch    = 1'b0;
        w_scan     = 1'b0;
        w_drop     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A frame without valid positions is skipped entirely.
                if (bus.nf_in && bus.ball_valid) begin
                    w_latch    = 1'b1;
                    w_state_nx = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_scan = 1'b1;
                w_drop = bus.nf_in;
                if (r_idx == c_LAST_BALL) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Frame snapshot; the scan walks this copy, not the live inputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_idx   <= 3'd0;
            r_catch <= 10'd0;
            r_nb    <= 3'd0;
            r_fpb   <= 15'd1;
            for (int i = 0; i < 7; i++) begin
                r_y[i] <= 10'd0;
            end
        end else if (w_latch) begin
            r_idx   <= 3'd0;
            r_catch <= bus.catch_y_in;
            r_nb    <= bus.num_balls;
            r_fpb   <= (bus.frame_per_beat == 15'd0) ? 15'd1 : bus.frame_per_beat;
            for (int i = 0; i < 7; i++) begin
                r_y[i] <= bus.ball_y_in[i];
            end
        end else if (w_scan) begin
            r_idx <= r_idx + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Per-ball tracking, one ball per scan cycle
    // ------------------------------------------------------------------
    logic        r_air   [0:6];
    logic [14:0] r_sub   [0:6];
    logic [2:0]  r_beats [0:6];

    logic        w_active;
    logic [9:0]  w_y;
    logic        w_air;
    logic [14:0] w_sub;
    logic [2:0]  w_beats;
    logic [10:0] w_thr;
    logic        w_rise;
    logic [14:0] w_sub_inc;
    logic [14:0] w_sub_adv;
    logic [2:0]  w_beats_adv;
    logic        w_half;
    logic [3:0]  w_digit_sum;
    logic [2:0]  w_digit;
    logic        w_air_nx;
    logic [14:0] w_sub_nx;
    logic [2:0]  w_beats_nx;
    logic        w_push;
    logic [5:0]  w_push_data;

    always_comb begin
        w_active    = w_scan && (r_idx < r_nb);
        w_y         = r_y[r_idx];
        w_air       = r_air[r_idx];
        w_sub       = r_sub[r_idx];
        w_beats     = r_beats[r_idx];

        // Signed 11-bit threshold: a catch line closer than THRESH to the
        // top of the screen goes negative and no ball can ever rise above it.
        w_thr       = {1'b0, r_catch} - c_THRESH;
        w_rise      = $signed({1'b0, w_y}) < $signed(w_thr);

        w_sub_inc   = w_sub + 15'd1;
        w_sub_adv   = w_sub_inc;
        w_beats_adv = w_beats;
        if (w_sub_inc == r_fpb) begin
            w_sub_adv   = 15'd0;
            w_beats_adv = (w_beats == 3'd7) ? 3'd7 : w_beats + 3'd1;
        end

        // Round to the nearest beat using the post-increment remainder.
        w_half      = (w_sub_adv >= (r_fpb >> 1));
        w_digit_sum = {1'b0, w_beats_adv} + {3'b000, w_half};
        w_digit     = (w_digit_sum > 4'd7) ? 3'd7 : w_digit_sum[2:0];

        w_air_nx    = w_air;
        w_sub_nx    = w_sub;
        w_beats_nx  = w_beats;
        w_push      = 1'b0;
        w_push_data = 6'd0;

        if (w_active) begin
            if (!w_air) begin
                if (w_rise) begin
                    w_air_nx   = 1'b1;
                    w_sub_nx   = 15'd0;
                    w_beats_nx = 3'd0;
                end
`ifdef SITESWAP_HOLD_DETECT_EN
                else if ((w_beats_adv == 3'd2) && (w_sub_adv == 15'd0)) begin
                    // Two full beats in hand: a held "2" throw.
                    w_push      = 1'b1;
                    w_push_data = {r_idx, 3'd2};
                    w_sub_nx    = 15'd0;
                    w_beats_nx  = 3'd0;
                end else begin
                    w_sub_nx   = w_sub_adv;
                    w_beats_nx = w_beats_adv;
                end
`endif
            end else if (w_rise) begin
                w_sub_nx   = w_sub_adv;
                w_beats_nx = w_beats_adv;
            end else begin
                // Catch: the catch frame itself counts towards airtime.
                w_air_nx   = 1'b0;
                w_sub_nx   = 15'd0;
                w_beats_nx = 3'd0;
                if (w_digit != 3'd0) begin
                    w_push      = 1'b1;
                    w_push_data = {r_idx, w_digit};
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 7; i++) begin
                r_air[i]   <= 1'b0;
                r_sub[i]   <= 15'd0;
                r_beats[i] <= 3'd0;
            end
        end else if (w_active) begin
            r_air[r_idx]   <= w_air_nx;
            r_sub[r_idx]   <= w_sub_nx;
            r_beats[r_idx] <= w_beats_nx;
        end
    end

    // ------------------------------------------------------------------
    // Digit FIFO: {ball[2:0], digit[2:0]} entries
    // ------------------------------------------------------------------
    logic [5:0]    r_mem [0:FIFO_DEPTH-1];
    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;
    logic          r_overflow;
    logic          r_frame_drop;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr;
    logic [5:0]    w_head;

    always_comb begin
        w_empty = (r_wptr == r_rptr);
        w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                  (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
        w_pop   = !w_empty && bus.digit_ready;
        // A pop in the same cycle frees the slot the push needs.
        w_wr    = w_push && (!w_full || w_pop);
        w_head  = r_mem[r_rptr[c_AW-1:0]];
    end

    always_ff @(posedge clk_in) begin
        if (w_wr) begin
            r_mem[r_wptr[c_AW-1:0]] <= w_push_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_overflow   <= 1'b0;
            r_frame_drop <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_wr) begin
                r_overflow <= 1'b1;
            end
            if (w_drop) begin
                r_frame_drop <= 1'b1;
            end
        end
    end

    // Head fields are forced to zero while empty so the idle outputs are clean.
    assign bus.digit_valid    = !w_empty;
    assign bus.digit_out      = w_empty ? 3'd0 : w_head[2:0];
    assign bus.digit_ball_out = w_empty ? 3'd0 : w_head[5:3];
    assign bus.overflow       = r_overflow;
    assign bus.frame_drop     = r_frame_drop;

endmodule
`default_nettype wire

// File: tb/tb_siteswap_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_siteswap_decoder                                        |
// | Description : Directed self-checking bench for siteswap_decoder.         |
// |               Frames are driven one at a time with the scan allowed to   |
// |               finish; expected digits are hand-computed from airtime.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_siteswap_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         errors = 0;
    int         checks = 0;
    logic [9:0] ys [0:6];
    logic       v1;
    logic       v2;
    logic       pv;
    logic [2:0] pd;
    logic [2:0] pb;

    siteswap_decoder_if bus ();

    siteswap_decoder #(
        .THRESH     (20),
        .FIFO_DEPTH (8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One frame; v1/v2 hold digit_valid one and two cycles after nf_in.
    task automatic frame(input logic bv);
        @(posedge clk); #1;
        bus.nf_in      = 1'b1;
        bus.ball_valid = bv;
        for (int i = 0; i < 7; i++) bus.ball_y_in[i] = ys[i];
        @(posedge clk); #1;
        bus.nf_in      = 1'b0;
        bus.ball_valid = 1'b0;
        v1 = bus.digit_valid;
        @(posedge clk); #1;
        v2 = bus.digit_valid;
        repeat (7) @(posedge clk);
        #1;
    endtask

    // Launch ball b, keep it up for n frames total, then catch it.
    task automatic flight(input int b, input int n);
        ys[b] = 10'd300;
        repeat (n) frame(1'b1);
        ys[b] = 10'd400;
        frame(1'b1);
    endtask

    // Capture the FIFO head, then accept it for one cycle.
    task automatic pop();
        #1;
        pv = bus.digit_valid;
        pd = bus.digit_out;
        pb = bus.digit_ball_out;
        bus.digit_ready = 1'b1;
        @(posedge clk); #1;
        bus.digit_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({bus.digit_valid, bus.digit_out, bus.digit_ball_out, bus.overflow, bus.frame_drop} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0", {bus.digit_valid, bus.digit_out, bus.digit_ball_out, bus.overflow, bus.frame_drop});
        end
    endtask

    task automatic test_basic();
        bus.catch_y_in = 10'd400; bus.frame_per_beat = 15'd30; bus.num_balls = 3'd1;
        flight(0, 90);
        checks++;
        if (v1 !== 1'b0) begin errors++; $display("FAIL basic_valid_nf+1 got %b exp 0", v1); end
        checks++;
        if (v2 !== 1'b1) begin errors++; $display("FAIL basic_valid_nf+2 got %b exp 1", v2); end
        pop();
        checks++;
        if ({pv, pb, pd} !== {1'b1, 3'd0, 3'd3}) begin errors++; $display("FAIL basic_digit got v%b b%0d d%0d exp v1 b0 d3", pv, pb, pd); end
        checks++;
        if (bus.digit_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", bus.digit_valid); end
    endtask

    task automatic test_rounding();
        flight(0, 104);
        pop();
        checks++;
        if ({pv, pd} !== {1'b1, 3'd3}) begin errors++; $display("FAIL round_down got v%b d%0d exp v1 d3", pv, pd); end
        flight(0, 105);
        pop();
        checks++;
        if ({pv, pd} !== {1'b1, 3'd4}) begin errors++; $display("FAIL round_up got v%b d%0d exp v1 d4", pv, pd); end
    endtask

    task automatic test_saturate();
        flight(0, 300);
        pop();
        checks++;
        if ({pv, pd} !== {1'b1, 3'd7}) begin errors++; $display("FAIL saturate got v%b d%0d exp v1 d7", pv, pd); end
    endtask

    task automatic test_low_rise();
        ys[0] = 10'd385;
        repeat (10) frame(1'b1);
        ys[0] = 10'd400;
        frame(1'b1);
        checks++;
        if (bus.digit_valid !== 1'b0) begin errors++; $display("FAIL low_rise_valid got %b exp 0", bus.digit_valid); end
    endtask

    task automatic test_multi();
        int eb [6];
        int ed [6];
        int n;
        apply_reset();
        bus.num_balls = 3'd3;
`ifdef SITESWAP_HOLD_DETECT_EN
        // Balls 1/2 sit in hand for 60/120 frames first and report held 2s.
        eb = '{1, 2, 2, 0, 1, 2};
        ed = '{2, 2, 2, 5, 3, 1};
        n  = 6;
`else
        eb = '{0, 1, 2, 0, 0, 0};
        ed = '{5, 3, 1, 0, 0, 0};
        n  = 3;
`endif
        ys[0] = 10'd300;
        repeat (60) frame(1'b1);
        ys[1] = 10'd300;
        repeat (60) frame(1'b1);
        ys[2] = 10'd300;
        repeat (30) frame(1'b1);
        ys[0] = 10'd400; ys[1] = 10'd400; ys[2] = 10'd400;
        frame(1'b1);
        for (int k = 0; k < n; k++) begin
            pop();
            checks++;
            if ({pv, pb, pd} !== {1'b1, 3'(eb[k]), 3'(ed[k])}) begin
                errors++;
                $display("FAIL multi_order[%0d] got v%b b%0d d%0d exp v1 b%0d d%0d", k, pv, pb, pd, eb[k], ed[k]);
            end
        end
        checks++;
        if (bus.digit_valid !== 1'b0) begin errors++; $display("FAIL multi_empty got %b exp 0", bus.digit_valid); end
    endtask

    task automatic test_ignored_ball();
        flight(3, 40);
        checks++;
        if (bus.digit_valid !== 1'b0) begin errors++; $display("FAIL ignored_ball got %b exp 0", bus.digit_valid); end
    endtask

    task automatic test_overflow();
        int ds [9];
        ds = '{1, 2, 3, 4, 5, 6, 7, 1, 2};
        bus.num_balls = 3'd1; bus.frame_per_beat = 15'd2;
        for (int k = 0; k < 9; k++) begin
            flight(0, 2 * ds[k]);
            if (k == 7) begin
                checks++;
                if (bus.overflow !== 1'b0) begin errors++; $display("FAIL overflow_early got %b exp 0", bus.overflow); end
            end
        end
        checks++;
        if ({bus.overflow, bus.digit_valid} !== 2'b11) begin errors++; $display("FAIL overflow_set got ovf%b v%b exp ovf1 v1", bus.overflow, bus.digit_valid); end
        for (int k = 0; k < 8; k++) begin
            pop();
            checks++;
            if ({pv, pb, pd} !== {1'b1, 3'd0, 3'(ds[k])}) begin
                errors++;
                $display("FAIL overflow_drain[%0d] got v%b b%0d d%0d exp v1 b0 d%0d", k, pv, pb, pd, ds[k]);
            end
        end
        checks++;
        if ({bus.overflow, bus.digit_valid} !== 2'b10) begin errors++; $display("FAIL overflow_after got ovf%b v%b exp ovf1 v0", bus.overflow, bus.digit_valid); end
    endtask

    task automatic test_frame_drop();
        checks++;
        if (bus.frame_drop !== 1'b0) begin errors++; $display("FAIL frame_drop_clear got %b exp 0", bus.frame_drop); end
        @(posedge clk); #1;
        bus.nf_in = 1'b1; bus.ball_valid = 1'b1;
        @(posedge clk); #1;
        bus.nf_in = 1'b0; bus.ball_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.nf_in = 1'b1; bus.ball_valid = 1'b1;
        @(posedge clk); #1;
        bus.nf_in = 1'b0; bus.ball_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (bus.frame_drop !== 1'b1) begin errors++; $display("FAIL frame_drop_set got %b exp 1", bus.frame_drop); end
    endtask

    task automatic test_reset_mid_scan();
        bus.frame_per_beat = 15'd30;
        flight(0, 30);
        checks++;
        if (bus.digit_valid !== 1'b1) begin errors++; $display("FAIL rstscan_pre_valid got %b exp 1", bus.digit_valid); end
        ys[0] = 10'd300;
        repeat (41) frame(1'b1);
        @(posedge clk); #1;
        bus.nf_in = 1'b1; bus.ball_valid = 1'b1;
        @(posedge clk); #1;
        bus.nf_in = 1'b0; bus.ball_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({bus.digit_valid, bus.digit_out, bus.digit_ball_out, bus.overflow, bus.frame_drop} !== 9'd0) begin
            errors++;
            $display("FAIL rstscan_outputs got %b exp 0", {bus.digit_valid, bus.digit_out, bus.digit_ball_out, bus.overflow, bus.frame_drop});
        end
        ys[0] = 10'd400;
        frame(1'b1);
        checks++;
        if (bus.digit_valid !== 1'b0) begin errors++; $display("FAIL rstscan_catch got %b exp 0", bus.digit_valid); end
    endtask

`ifdef SITESWAP_HOLD_DETECT_EN
    task automatic test_hold();
        apply_reset();
        bus.frame_per_beat = 15'd30; bus.num_balls = 3'd1;
        ys[0] = 10'd400;
        repeat (59) frame(1'b1);
        checks++;
        if (bus.digit_valid !== 1'b0) begin errors++; $display("FAIL hold_early got %b exp 0", bus.digit_valid); end
        frame(1'b1);
        pop();
        checks++;
        if ({pv, pb, pd} !== {1'b1, 3'd0, 3'd2}) begin errors++; $display("FAIL hold_digit got v%b b%0d d%0d exp v1 b0 d2", pv, pb, pd); end
    endtask
`endif

    initial begin
        bus.nf_in          = 1'b0;
        bus.ball_valid     = 1'b0;
        bus.ball_x_in      = '0;
        bus.ball_y_in      = '0;
        bus.catch_y_in     = 10'd400;
        bus.num_balls      = 3'd1;
        bus.frame_per_beat = 15'd30;
        bus.digit_ready    = 1'b0;
        for (int i = 0; i < 7; i++) ys[i] = 10'd400;

        test_reset();
        test_basic();
        test_rounding();
        test_saturate();
        test_low_rise();
        test_multi();
        test_ignored_ball();
        test_overflow();
        test_frame_drop();
        test_reset_mid_scan();
`ifdef SITESWAP_HOLD_DETECT_EN
        test_hold();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
